intf_rr_mux: RTL

INTF_RR_MUX -- requirements
Module: intf_rr_mux

---
 rtl/intf_rr_mux_pkg.sv | 13 +
 rtl/intf_rr_mux_if.sv | 32 +++
 rtl/intf_rr_mux_rr_pick.sv | 41 ++++
 rtl/intf_rr_mux.sv | 85 ++++++++
 4 files changed

// File: rtl/intf_rr_mux_pkg.sv
// Shared constants and helpers for the round-robin channel multiplexer.
package intf_rr_pkg;

  localparam int DEF_NCHAN = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNTW  = 16;

  // Channel-index width: a single channel still needs one bit so out_chan exists.
  function automatic int chw_of(input int nchan);
    return (nchan <= 1) ? 1 : $clog2(nchan);
  endfunction

endpackage

// File: rtl/intf_rr_mux_if.sv
// Upstream channel bundle plus downstream valid/ready port of the multiplexer.
interface intf_rr_mux_if
  import intf_rr_pkg::*;
#(
  parameter int NCHAN = DEF_NCHAN,
  parameter int WIDTH = DEF_WIDTH
);

  localparam int CHW = chw_of(NCHAN);

  logic [NCHAN-1:0]       chan_enable;
  logic [NCHAN-1:0]       in_valid;
  logic [NCHAN*WIDTH-1:0] in_data;
  logic [NCHAN-1:0]       in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [CHW-1:0]         out_chan;

  // The multiplexer side.
  modport slave (
    input  chan_enable, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

  // The environment side: drives channels and consumes the output.
  modport master (
    output chan_enable, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );

endinterface

// File: rtl/intf_rr_mux_rr_pick.sv
// Combinational round-robin priority encoder: the first requester strictly
// after 'last' wins, wrapping around to the lowest indices.
module rr_pick
  import intf_rr_pkg::*;
#(
  parameter int NCHAN = DEF_NCHAN,
  localparam int CHW = chw_of(NCHAN)
) (
  input  logic [NCHAN-1:0] req,
  input  logic [CHW-1:0]   last,
  output logic [NCHAN-1:0] grant,
  output logic [CHW-1:0]   index,
  output logic             any
);

  logic found;

  // Two passes: channels above the last winner first, then the wrapped-around lower half.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!found && req[i] && (i > int'(last))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = CHW'(i);
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      if (!found && req[i] && (i <= int'(last))) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        index    = CHW'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/intf_rr_mux.sv
// Round-robin N:1 multiplexer feeding a single registered valid/ready stage,
// with a count of completed output transfers.
module intf_rr_mux
  import intf_rr_pkg::*;
#(
  parameter int NCHAN = DEF_NCHAN,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNTW  = DEF_CNTW,
  localparam int CHW  = chw_of(NCHAN)
) (
  input  logic            clk,
  input  logic            reset,
  intf_rr_mux_if.slave    bus,
  output logic [CNTW-1:0] xfer_count
);

  logic [NCHAN-1:0] eligible;
  logic [NCHAN-1:0] grant;
  logic [CHW-1:0]   index;
  logic             any;
  logic             load;
  logic [WIDTH-1:0] sel_data;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [CHW-1:0]   chan_q;
  logic [CHW-1:0]   last_grant;
  logic [CNTW-1:0]  count_q;

  // A disabled channel drops out of arbitration in the same cycle.
  assign eligible = bus.in_valid & bus.chan_enable;

  rr_pick #(
    .NCHAN (NCHAN)
  ) u_pick (
    .req   (eligible),
    .last  (last_grant),
    .grant (grant),
    .index (index),
    .any   (any)
  );

  // Accept only when the output register is empty or draining; never during reset.
  assign load         = !reset && (!valid_q || bus.out_ready) && any;
  assign bus.in_ready = load ? grant : '0;

  // Steer the granted channel's payload toward the output register.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (grant[i]) begin
        sel_data = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register, arbitration pointer and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      chan_q     <= '0;
      count_q    <= '0;
      last_grant <= CHW'(NCHAN - 1);
    end else begin
      if (valid_q && bus.out_ready) begin
        count_q <= count_q + CNTW'(1);
      end
      if (load) begin
        valid_q    <= 1'b1;
        data_q     <= sel_data;
        chan_q     <= index;
        last_grant <= index;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign xfer_count    = count_q;

endmodule
